// File: rtl/mf_timekeeper_pkg.sv
// Shared types and helpers for the multi-function timekeeper.
// Provides mode encoding, field indices and wrap-around step arithmetic.
package mf_timekeeper_pkg;

  typedef enum logic [1:0] {
    MODE_RTC = 2'b00,
    MODE_SET = 2'b01,
    MODE_SW  = 2'b10,
    MODE_TMR = 2'b11
  } mode_e;

  typedef enum logic [0:0] {
    StIdle,
    StRing
  } ring_state_e;

  localparam int unsigned F_SEC   = 0;
  localparam int unsigned F_MIN   = 1;
  localparam int unsigned F_HOUR  = 2;
  localparam int unsigned SEC_MAX = 60;
  localparam int unsigned MIN_MAX = 60;

  function automatic logic [7:0] wrap_inc(logic [7:0] v, int unsigned modulus);
    return (v >= 8'(modulus - 1)) ? 8'd0 : v + 8'd1;
  endfunction

  function automatic logic [7:0] wrap_dec(logic [7:0] v, int unsigned modulus);
    return (v == 8'd0) ? 8'(modulus - 1) : v - 8'd1;
  endfunction

  // Simultaneous up and down on one field cancel out.
  function automatic logic [7:0] wrap_step(logic [7:0] v, logic up, logic dn,
                                           int unsigned modulus);
    if (up && !dn) return wrap_inc(v, modulus);
    if (dn && !up) return wrap_dec(v, modulus);
    return v;
  endfunction

endpackage

// File: rtl/hms_counter.sv
// Hours/minutes/seconds counter with cascaded tick up/down and per-field
// wrap-around adjust steps (no carry between fields on adjust).
module hms_counter
  import mf_timekeeper_pkg::*;
#(
  parameter int unsigned HOUR_MAX = 24
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_up_i,
  input  logic       tick_dn_i,
  input  logic       clr_i,
  input  logic [2:0] inc_i,
  input  logic [2:0] dec_i,
  output logic [7:0] hour_o,
  output logic [7:0] min_o,
  output logic [7:0] sec_o,
  output logic       is_zero_o
);

  logic [7:0] h_q, h_d, m_q, m_d, s_q, s_d;

  always_comb begin
    h_d = h_q;
    m_d = m_q;
    s_d = s_q;
    if (clr_i) begin
      h_d = '0;
      m_d = '0;
      s_d = '0;
    end else if (tick_up_i) begin
      s_d = wrap_inc(s_q, SEC_MAX);
      if (s_q == 8'(SEC_MAX - 1)) begin
        m_d = wrap_inc(m_q, MIN_MAX);
        if (m_q == 8'(MIN_MAX - 1)) h_d = wrap_inc(h_q, HOUR_MAX);
      end
    end else if (tick_dn_i) begin
      s_d = wrap_dec(s_q, SEC_MAX);
      if (s_q == 8'd0) begin
        m_d = wrap_dec(m_q, MIN_MAX);
        if (m_q == 8'd0) h_d = wrap_dec(h_q, HOUR_MAX);
      end
    end else begin
      s_d = wrap_step(s_q, inc_i[F_SEC], dec_i[F_SEC], SEC_MAX);
      m_d = wrap_step(m_q, inc_i[F_MIN], dec_i[F_MIN], MIN_MAX);
      h_d = wrap_step(h_q, inc_i[F_HOUR], dec_i[F_HOUR], HOUR_MAX);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q <= '0;
      m_q <= '0;
      s_q <= '0;
    end else begin
      h_q <= h_d;
      m_q <= m_d;
      s_q <= s_d;
    end
  end

  assign hour_o    = h_q;
  assign min_o     = m_q;
  assign sec_o     = s_q;
  assign is_zero_o = (h_q == 8'd0) && (m_q == 8'd0) && (s_q == 8'd0);

endmodule

// File: rtl/mf_timekeeper.sv
// Multi-function timekeeper: RTC, stopwatch, countdown timer and alarm bank on one display.
// Define MF_LAP_EN to enable the stopwatch lap-freeze display feature.
module mf_timekeeper
  import mf_timekeeper_pkg::*;
#(
  parameter  int unsigned TICK_DIV   = 50_000_000,
  parameter  int unsigned NUM_ALARMS = 4,
  parameter  int unsigned HOUR_MAX   = 24,
  parameter  int unsigned RING_SECS  = 30,
  localparam int unsigned AW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            mode_i,
  input  logic [2:0]            adj_inc_i,
  input  logic [2:0]            adj_dec_i,
  input  logic                  start_stop_i,
  input  logic                  clear_i,
  input  logic                  lap_i,
  input  logic                  alarm_wr_i,
  input  logic [AW-1:0]         alarm_idx_i,
  input  logic [7:0]            alarm_hour_i,
  input  logic [7:0]            alarm_min_i,
  input  logic [NUM_ALARMS-1:0] alarm_en_i,
  input  logic                  ring_ack_i,
  output logic                  ring_o,
  output logic                  led_o,
  output logic [7:0]            hour_o,
  output logic [7:0]            minute_o,
  output logic [7:0]            second_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RW = $clog2(RING_SECS + 1);

  mode_e mode;
  assign mode = mode_e'(mode_i);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;
  assign tick  = (pre_q == PW'(TICK_DIV - 1));
  assign pre_d = tick ? '0 : pre_q + PW'(1);

  logic [2:0] inc_prev_q, dec_prev_q, inc_edge, dec_edge;
  logic       ss_prev_q, clr_prev_q, ss_edge, clr_edge;
  assign inc_edge = adj_inc_i & ~inc_prev_q;
  assign dec_edge = adj_dec_i & ~dec_prev_q;
  assign ss_edge  = start_stop_i & ~ss_prev_q;
  assign clr_edge = clear_i & ~clr_prev_q;

  logic       sw_run_q, sw_run_d, tmr_run_q, tmr_run_d, led_q;
  logic [7:0] rtc_h, rtc_m, rtc_s, sw_h, sw_m, sw_s, tmr_h, tmr_m, tmr_s;
  logic       rtc_zero_unused, sw_zero_unused, tmr_zero;
  logic       rtc_tick, set_mode, tmr_adj, tmr_expire;

  assign set_mode   = (mode == MODE_SET);
  assign rtc_tick   = tick & ~set_mode;
  assign tmr_adj    = (mode == MODE_TMR) & ~tmr_run_q;
  assign tmr_expire = tick & tmr_run_q & (tmr_h == 8'd0) & (tmr_m == 8'd0) & (tmr_s == 8'd1);

  hms_counter #(.HOUR_MAX(HOUR_MAX)) u_rtc (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .tick_up_i (rtc_tick),
    .tick_dn_i (1'b0),
    .clr_i     (1'b0),
    .inc_i     (set_mode ? inc_edge : 3'b000),
    .dec_i     (set_mode ? dec_edge : 3'b000),
    .hour_o    (rtc_h),
    .min_o     (rtc_m),
    .sec_o     (rtc_s),
    .is_zero_o (rtc_zero_unused)
  );

  hms_counter #(.HOUR_MAX(HOUR_MAX)) u_sw (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .tick_up_i (tick & sw_run_q),
    .tick_dn_i (1'b0),
    .clr_i     (clr_edge & (mode == MODE_SW) & ~sw_run_q),
    .inc_i     (3'b000),
    .dec_i     (3'b000),
    .hour_o    (sw_h),
    .min_o     (sw_m),
    .sec_o     (sw_s),
    .is_zero_o (sw_zero_unused)
  );

  hms_counter #(.HOUR_MAX(HOUR_MAX)) u_tmr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .tick_up_i (1'b0),
    .tick_dn_i (tick & tmr_run_q & ~tmr_zero),
    .clr_i     (1'b0),
    .inc_i     (tmr_adj ? inc_edge : 3'b000),
    .dec_i     (tmr_adj ? dec_edge : 3'b000),
    .hour_o    (tmr_h),
    .min_o     (tmr_m),
    .sec_o     (tmr_s),
    .is_zero_o (tmr_zero)
  );

  always_comb begin
    sw_run_d  = sw_run_q;
    tmr_run_d = tmr_run_q;
    if (ss_edge && mode == MODE_SW)  sw_run_d  = ~sw_run_q;
    if (ss_edge && mode == MODE_TMR) tmr_run_d = ~tmr_run_q & ~tmr_zero;
    if (tmr_expire)                  tmr_run_d = 1'b0;
  end

  logic [7:0] sw_disp_h, sw_disp_m, sw_disp_s;
`ifdef MF_LAP_EN
  logic       lap_prev_q, lap_edge, lap_act_q, lap_act_d;
  logic [7:0] lap_h_q, lap_m_q, lap_s_q;
  assign lap_edge = lap_i & ~lap_prev_q;

  always_comb begin
    lap_act_d = lap_act_q;
    if (mode == MODE_SW && sw_run_q) begin
      if (ss_edge)       lap_act_d = 1'b0;
      else if (lap_edge) lap_act_d = ~lap_act_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lap_prev_q <= 1'b0;
      lap_act_q  <= 1'b0;
      lap_h_q    <= '0;
      lap_m_q    <= '0;
      lap_s_q    <= '0;
    end else begin
      lap_prev_q <= lap_i;
      lap_act_q  <= lap_act_d;
      if (lap_act_d && !lap_act_q) begin
        lap_h_q <= sw_h;
        lap_m_q <= sw_m;
        lap_s_q <= sw_s;
      end
    end
  end

  assign sw_disp_h = lap_act_q ? lap_h_q : sw_h;
  assign sw_disp_m = lap_act_q ? lap_m_q : sw_m;
  assign sw_disp_s = lap_act_q ? lap_s_q : sw_s;
`else
  logic unused_lap;
  assign unused_lap = lap_i;
  assign sw_disp_h  = sw_h;
  assign sw_disp_m  = sw_m;
  assign sw_disp_s  = sw_s;
`endif

  logic [7:0] al_h_q [NUM_ALARMS];
  logic [7:0] al_m_q [NUM_ALARMS];
  logic       al_wr_ok, alarm_hit;
  logic [7:0] nxt_h, nxt_m;
  assign al_wr_ok = alarm_wr_i & (alarm_hour_i < 8'(HOUR_MAX)) & (alarm_min_i < 8'(MIN_MAX));

  // Compare against the RTC value this tick is about to produce (always hh:mm:00).
  always_comb begin
    nxt_m     = wrap_inc(rtc_m, MIN_MAX);
    nxt_h     = (rtc_m == 8'(MIN_MAX - 1)) ? wrap_inc(rtc_h, HOUR_MAX) : rtc_h;
    alarm_hit = 1'b0;
    if (rtc_tick && rtc_s == 8'(SEC_MAX - 1)) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (alarm_en_i[i] && al_h_q[i] == nxt_h && al_m_q[i] == nxt_m) alarm_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        al_h_q[i] <= '0;
        al_m_q[i] <= '0;
      end
    end else if (al_wr_ok) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (alarm_idx_i == AW'(i)) begin
          al_h_q[i] <= alarm_hour_i;
          al_m_q[i] <= alarm_min_i;
        end
      end
    end
  end

  ring_state_e   ring_st_q, ring_st_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic          ring_trig;
  assign ring_trig = alarm_hit | tmr_expire;

  always_comb begin
    ring_st_d  = ring_st_q;
    ring_cnt_d = ring_cnt_q;
    unique case (ring_st_q)
      StIdle: begin
        if (ring_trig) begin
          ring_st_d  = StRing;
          ring_cnt_d = '0;
        end
      end
      StRing: begin
        if (ring_trig) begin
          ring_cnt_d = '0;
        end else if (ring_ack_i) begin
          ring_st_d = StIdle;
        end else if (tick) begin
          if (ring_cnt_q == RW'(RING_SECS - 1)) ring_st_d = StIdle;
          else                                  ring_cnt_d = ring_cnt_q + RW'(1);
        end
      end
      default: ring_st_d = StIdle;
    endcase
  end

  always_comb begin
    ring_o = (ring_st_q == StRing);
  end

  logic [7:0] disp_h, disp_m, disp_s, hour_q, min_q, sec_q;
  always_comb begin
    disp_h = rtc_h;
    disp_m = rtc_m;
    disp_s = rtc_s;
    unique case (mode)
      MODE_RTC, MODE_SET: ;
      MODE_SW: begin
        disp_h = sw_disp_h;
        disp_m = sw_disp_m;
        disp_s = sw_disp_s;
      end
      MODE_TMR: begin
        disp_h = tmr_h;
        disp_m = tmr_m;
        disp_s = tmr_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q      <= '0;
      inc_prev_q <= '0;
      dec_prev_q <= '0;
      ss_prev_q  <= 1'b0;
      clr_prev_q <= 1'b0;
      sw_run_q   <= 1'b0;
      tmr_run_q  <= 1'b0;
      led_q      <= 1'b0;
      ring_st_q  <= StIdle;
      ring_cnt_q <= '0;
      hour_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
    end else begin
      pre_q      <= pre_d;
      inc_prev_q <= adj_inc_i;
      dec_prev_q <= adj_dec_i;
      ss_prev_q  <= start_stop_i;
      clr_prev_q <= clear_i;
      sw_run_q   <= sw_run_d;
      tmr_run_q  <= tmr_run_d;
      led_q      <= sw_run_q | tmr_run_q;
      ring_st_q  <= ring_st_d;
      ring_cnt_q <= ring_cnt_d;
      hour_q     <= disp_h;
      min_q      <= disp_m;
      sec_q      <= disp_s;
    end
  end

  assign led_o    = led_q;
  assign hour_o   = hour_q;
  assign minute_o = min_q;
  assign second_o = sec_q;

endmodule

// File: tb/tb_mf_timekeeper.sv
// Scoreboard bench for mf_timekeeper: a seconds-based reference model predicts every
// display/ring/led sample; a monitor pops and compares at each falling edge.
module tb_mf_timekeeper;

  localparam int unsigned TD = 4, NA = 4, HM = 24, RS = 30;
  localparam int DAY = HM * 3600;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [1:0] mode = '0, alarm_idx = '0;
  logic [2:0] adj_inc = '0, adj_dec = '0;
  logic       start_stop = 1'b0, clear = 1'b0, lap = 1'b0, alarm_wr = 1'b0, ring_ack = 1'b0;
  logic [7:0] alarm_hour = '0, alarm_min = '0;
  logic [3:0] alarm_en = '0;
  logic       ring, led;
  logic [7:0] hour, minute, second;

  always #5 clk = ~clk;

  mf_timekeeper #(.TICK_DIV(TD), .NUM_ALARMS(NA), .HOUR_MAX(HM), .RING_SECS(RS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .adj_inc_i(adj_inc), .adj_dec_i(adj_dec),
    .start_stop_i(start_stop), .clear_i(clear), .lap_i(lap), .alarm_wr_i(alarm_wr),
    .alarm_idx_i(alarm_idx), .alarm_hour_i(alarm_hour), .alarm_min_i(alarm_min),
    .alarm_en_i(alarm_en), .ring_ack_i(ring_ack), .ring_o(ring), .led_o(led),
    .hour_o(hour), .minute_o(minute), .second_o(second)
  );

  typedef struct packed {logic r; logic l; logic [7:0] h; logic [7:0] m; logic [7:0] s;} obs_t;
  obs_t exp_q[$];
  int checks = 0, errors = 0;

  // Reference model: every count is plain seconds.
  int pc, rtc, sw, tmr, lap_val, ring_cnt;
  bit sw_run, tmr_run, lap_act, m_ring;
  int al_h[NA], al_m[NA];
  bit [2:0] p_inc, p_dec;
  bit p_ss, p_clr, p_lap;

  function automatic int step_fields(int t, bit [2:0] up, bit [2:0] dn);
    int f[3];
    int md[3];
    md = '{60, 60, HM};
    f[0] = t % 60; f[1] = (t / 60) % 60; f[2] = t / 3600;
    for (int k = 0; k < 3; k++) begin
      if (up[k] && !dn[k]) f[k] = (f[k] + 1) % md[k];
      else if (dn[k] && !up[k]) f[k] = (f[k] + md[k] - 1) % md[k];
    end
    return f[2] * 3600 + f[1] * 60 + f[0];
  endfunction

  function automatic obs_t mk(bit r, bit l, int t);
    obs_t o;
    o.r = r; o.l = l; o.h = 8'(t / 3600); o.m = 8'((t / 60) % 60); o.s = 8'(t % 60);
    return o;
  endfunction

  task automatic model_reset();
    pc = 0; rtc = 0; sw = 0; tmr = 0; lap_val = 0; ring_cnt = 0;
    sw_run = 0; tmr_run = 0; lap_act = 0; m_ring = 0;
    p_inc = 0; p_dec = 0; p_ss = 0; p_clr = 0; p_lap = 0;
    for (int i = 0; i < NA; i++) begin al_h[i] = 0; al_m[i] = 0; end
    exp_q.delete();
  endtask

  task automatic model_step();
    bit tick, ess, ecl, elp, hit, expire, led_n;
    bit [2:0] ei, ed;
    int disp_t, tmr_old, nrtc;
    tick = (pc == TD - 1);
    pc = tick ? 0 : pc + 1;
    ei = adj_inc & ~p_inc; ed = adj_dec & ~p_dec;
    ess = start_stop & !p_ss; ecl = clear & !p_clr; elp = lap & !p_lap;
    p_inc = adj_inc; p_dec = adj_dec; p_ss = start_stop; p_clr = clear; p_lap = lap;
    case (mode)
      2'd2:    disp_t = lap_act ? lap_val : sw;
      2'd3:    disp_t = tmr;
      default: disp_t = rtc;
    endcase
    led_n = sw_run | tmr_run;
    hit = 0;
    nrtc = (rtc + 1) % DAY;
    if (mode != 2'd1 && tick && nrtc % 60 == 0)
      for (int i = 0; i < NA; i++)
        if (alarm_en[i] && al_h[i] * 3600 + al_m[i] * 60 == nrtc) hit = 1;
    if (mode == 2'd1) rtc = step_fields(rtc, ei, ed);
    else if (tick) rtc = nrtc;
`ifdef MF_LAP_EN
    if (mode == 2'd2 && sw_run) begin
      if (ess) lap_act = 0;
      else if (elp) begin
        if (!lap_act) lap_val = sw;
        lap_act = !lap_act;
      end
    end
`endif
    if (mode == 2'd2 && ecl && !sw_run) sw = 0;
    else if (tick && sw_run) sw = (sw + 1) % DAY;
    if (mode == 2'd2 && ess) sw_run = !sw_run;
    expire = 0;
    tmr_old = tmr;
    if (mode == 2'd3 && !tmr_run) tmr = step_fields(tmr, ei, ed);
    else if (tmr_run && tick && tmr > 0) begin
      tmr--;
      expire = (tmr == 0);
    end
    if (mode == 2'd3 && ess) tmr_run = tmr_run ? 1'b0 : (tmr_old != 0);
    if (expire) tmr_run = 0;
    if (hit || expire) begin
      m_ring = 1; ring_cnt = 0;
    end else if (m_ring) begin
      if (ring_ack) m_ring = 0;
      else if (tick) begin
        if (ring_cnt == RS - 1) m_ring = 0;
        else ring_cnt++;
      end
    end
    if (alarm_wr && int'(alarm_idx) < NA && alarm_hour < HM && alarm_min < 60) begin
      al_h[alarm_idx] = int'(alarm_hour);
      al_m[alarm_idx] = int'(alarm_min);
    end
    exp_q.push_back(mk(m_ring, led_n, disp_t));
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Monitor: the registered outputs present a new sample every cycle.
  initial begin
    forever begin
      obs_t e;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({ring, led, hour, minute, second} !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t: got ring=%b led=%b %0d:%0d:%0d required ring=%b led=%b %0d:%0d:%0d",
                   $time, ring, led, hour, minute, second, e.r, e.l, e.h, e.m, e.s);
        end
      end
    end
  end

  task automatic check(string nm, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic press(bit dn, int f, int n);
    repeat (n) begin
      if (dn) adj_dec[f] = 1'b1; else adj_inc[f] = 1'b1;
      @(negedge clk);
      adj_inc = '0; adj_dec = '0;
      @(negedge clk);
    end
  endtask

  task automatic press_ss();
    start_stop = 1'b1; @(negedge clk); start_stop = 1'b0; @(negedge clk);
  endtask

  task automatic press_clr();
    clear = 1'b1; @(negedge clk); clear = 1'b0; @(negedge clk);
  endtask

  task automatic wait_ring(string nm, bit lvl, int budget);
    int n = 0;
    while (ring !== lvl && n < budget) begin @(negedge clk); n++; end
    check(nm, int'(ring), int'(lvl));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // RTC run: 240 cycles = 60 ticks, display lags one cycle.
    repeat (241) @(negedge clk);
    check("rtc_min", minute, 1); check("rtc_sec", second, 0); check("rtc_hour", hour, 0);
    check("rtc_led", led, 0); check("rtc_ring", ring, 0);
    // Countdown timer from 00:00:05.
    mode = 2'd3;
    press(1'b0, 0, 5);
    check("tmr_set", second, 5);
    press_ss();
    check("tmr_led_on", led, 1);
    wait_ring("tmr_ring", 1'b1, 40);
    @(negedge clk);
    check("tmr_zero", second, 0); check("tmr_led_off", led, 0);
    ring_ack = 1'b1; @(negedge clk); ring_ack = 1'b0;
    check("tmr_ack", ring, 0);
    // Stopwatch: clear while running is ignored, clear when stopped zeroes.
    mode = 2'd2;
    press_ss();
    repeat (46) @(negedge clk);
    press_clr();
    press_ss();
    press_clr();
    check("sw_clear", second, 0);
    // Async reset mid-cycle while the stopwatch runs.
    press_ss();
    repeat (30) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0; #1;
    check("rst_sec", second, 0); check("rst_led", led, 0); check("rst_ring", ring, 0);
    check("rst_hour", hour, 0);
    @(negedge clk); rst_n = 1'b1;
    // Alarm slot 2 at 07:30, RTC set to 07:29:59.
    mode = 2'd1;
    press(1'b0, 2, 7); press(1'b0, 1, 29); press(1'b1, 0, 1);
    check("set_hour", hour, 7); check("set_min", minute, 29); check("set_sec", second, 59);
    adj_inc[0] = 1'b1; adj_dec[0] = 1'b1; @(negedge clk); adj_inc = '0; adj_dec = '0;
    @(negedge clk);
    check("set_cancel", second, 59);
    alarm_wr = 1'b1; alarm_idx = 2'd2; alarm_hour = 8'd7; alarm_min = 8'd30;
    @(negedge clk);
    alarm_wr = 1'b0; alarm_en = 4'b0100; mode = 2'd0;
    wait_ring("alarm_ring", 1'b1, 10);
    repeat (100) @(negedge clk);
    check("alarm_hold", ring, 1);
    wait_ring("alarm_timeout", 1'b0, 40);
    check("alarm_min", minute, 30);
    // Randomised phase.
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      if (c == 4000) begin rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; end
      if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
      adj_inc = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      adj_dec = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      start_stop = ($urandom_range(0, 15) == 0);
      clear = ($urandom_range(0, 15) == 0);
      lap = ($urandom_range(0, 7) == 0);
      alarm_wr = ($urandom_range(0, 31) == 0);
      alarm_idx = 2'($urandom_range(0, 3));
      alarm_hour = 8'($urandom_range(0, 26));
      alarm_min = 8'($urandom_range(0, 62));
      if ($urandom_range(0, 127) == 0) alarm_en = 4'($urandom_range(0, 15));
      ring_ack = ($urandom_range(0, 39) == 0);
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
